d_mem_ctrl: RTL and testbench

- Data-memory responder for the MEM stage. It produces the d_ready that the hazard logic uses to self-stall MEM on loads.
- Converts single-cycle MEM-stage load/store requests into accesses to a fixed-latency external data memory.
- Keeps a one-entry load buffer. A repeated load to the same address completes without a memory access.
- Stores always complete in one cycle, so MEM never stalls on a store.

---
 rtl/d_mem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_d_mem_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/d_mem_ctrl.sv
// d_mem_ctrl: MEM-stage data-memory responder.
// Loads that miss the one-entry load buffer go to a fixed-latency external
// memory, and d_ready stalls MEM until the data returns. Loads that hit the
// buffer and all stores complete in the cycle they are presented.
module d_mem_ctrl #(
    parameter int WORD_SIZE   = 16,
    parameter int MEM_LATENCY = 2,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 d_mem_read,
    input  logic                 d_mem_write,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ready,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [15:0]          hit_count
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MEM_LATENCY - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [WORD_SIZE-1:0]  r_req_addr;
    logic                  r_buf_valid;
    logic [WORD_SIZE-1:0]  r_buf_addr;
    logic [WORD_SIZE-1:0]  r_buf_data;
    logic [15:0]           r_hit_count;

    logic                  w_match;
    logic                  w_store;
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_fill;
    logic                  w_d_ready;
    logic [WORD_SIZE-1:0]  w_d_rdata;
    logic                  w_mem_read;
    logic                  w_mem_write;
    logic [WORD_SIZE-1:0]  w_mem_addr;
    logic [WORD_SIZE-1:0]  w_mem_wdata;

    // Next-state decode and combinational request handshake.
    always_comb begin
        w_next_state = r_state;
        w_match      = r_buf_valid && (r_buf_addr == d_addr);
        w_store      = 1'b0;
        w_hit        = 1'b0;
        w_miss       = 1'b0;
        w_fill       = 1'b0;
        w_d_ready    = 1'b0;
        w_d_rdata    = {WORD_SIZE{1'b0}};
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_addr   = {WORD_SIZE{1'b0}};
        w_mem_wdata  = {WORD_SIZE{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (d_mem_write) begin
                    // A store wins over a simultaneous (illegal) load.
                    w_store     = 1'b1;
                    w_mem_write = 1'b1;
                    w_mem_addr  = d_addr;
                    w_mem_wdata = d_wdata;
                    w_d_ready   = 1'b1;
                end else if (d_mem_read && w_match) begin
                    w_hit     = 1'b1;
                    w_d_ready = 1'b1;
                    w_d_rdata = r_buf_data;
                end else if (d_mem_read) begin
                    w_miss       = 1'b1;
                    w_next_state = ST_WAIT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                w_mem_read = 1'b1;
                w_mem_addr = r_req_addr;
                if (r_cnt == {CNT_WIDTH{1'b0}}) begin
                    w_fill       = 1'b1;
                    w_d_ready    = 1'b1;
                    w_d_rdata    = mem_rdata;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are held at zero while reset is asserted.
    always_comb begin
        if (!reset_n) begin
            d_ready   = 1'b0;
            d_rdata   = {WORD_SIZE{1'b0}};
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mem_addr  = {WORD_SIZE{1'b0}};
            mem_wdata = {WORD_SIZE{1'b0}};
        end else begin
            d_ready   = w_d_ready;
            d_rdata   = w_d_rdata;
            mem_read  = w_mem_read;
            mem_write = w_mem_write;
            mem_addr  = w_mem_addr;
            mem_wdata = w_mem_wdata;
        end
    end

    assign hit_count = r_hit_count;

    // State register, latency counter and captured request address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= {CNT_WIDTH{1'b0}};
            r_req_addr <= {WORD_SIZE{1'b0}};
        end else begin
            r_state <= w_next_state;
            if (w_miss) begin
                r_cnt      <= CNT_LOAD;
                r_req_addr <= d_addr;
            end else if ((r_state == ST_WAIT) && (r_cnt != {CNT_WIDTH{1'b0}})) begin
                r_cnt <= r_cnt - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Load buffer: filled on miss completion, kept coherent on matching stores.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= {WORD_SIZE{1'b0}};
            r_buf_data  <= {WORD_SIZE{1'b0}};
        end else if (w_fill) begin
            r_buf_valid <= 1'b1;
            r_buf_addr  <= r_req_addr;
            r_buf_data  <= mem_rdata;
        end else if (w_store && w_match) begin
            r_buf_data <= d_wdata;
        end else begin
            r_buf_data <= r_buf_data;
        end
    end

    // Saturating count of load-buffer hits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_count <= 16'h0000;
        end else if (w_hit && (r_hit_count != 16'hFFFF)) begin
            r_hit_count <= r_hit_count + 16'h0001;
        end else begin
            r_hit_count <= r_hit_count;
        end
    end

endmodule

// File: tb/tb_d_mem_ctrl.sv
// Directed testbench for d_mem_ctrl with hand-computed expectations.
module tb_d_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        d_mem_read;
    logic        d_mem_write;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ready;
    logic [15:0] d_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] hit_count;

    int n_total = 0;
    int n_bad   = 0;

    d_mem_ctrl #(.WORD_SIZE(16), .MEM_LATENCY(2), .CNT_WIDTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .d_mem_read (d_mem_read),
        .d_mem_write(d_mem_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ready    (d_ready),
        .d_rdata    (d_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd);
        d_mem_read  = rd;
        d_mem_write = wr;
        d_addr      = a;
        d_wdata     = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        mem_rdata = 16'h0000;
        // A store presented during reset must not reach the outputs.
        drive(1'b0, 1'b1, 16'h0044, 16'h9999);

        @(negedge clk);
        check_val("rst_d_ready",   {31'd0, d_ready},   32'd0);
        check_val("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check_val("rst_mem_addr",  {16'd0, mem_addr},  32'd0);
        check_val("rst_hit_count", {16'd0, hit_count}, 32'd0);
        step();
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);

        // Idle with no request.
        @(negedge clk);
        check_val("idle_d_ready",  {31'd0, d_ready},  32'd0);
        check_val("idle_mem_read", {31'd0, mem_read}, 32'd0);
        check_val("idle_rdata",    {16'd0, d_rdata},  32'd0);
        step();

        // Load miss to 0x0010, memory returns 0xBEEF.
        mem_rdata = 16'hBEEF;
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        @(negedge clk);
        check_val("miss_c0_ready", {31'd0, d_ready},  32'd0);
        check_val("miss_c0_mrd",   {31'd0, mem_read}, 32'd0);
        step();
        @(negedge clk);
        check_val("miss_c1_ready", {31'd0, d_ready},  32'd0);
        check_val("miss_c1_mrd",   {31'd0, mem_read}, 32'd1);
        check_val("miss_c1_maddr", {16'd0, mem_addr}, 32'h0010);
        check_val("miss_c1_rdata", {16'd0, d_rdata},  32'd0);
        step();
        @(negedge clk);
        check_val("miss_c2_ready", {31'd0, d_ready},  32'd1);
        check_val("miss_c2_rdata", {16'd0, d_rdata},  32'hBEEF);
        check_val("miss_c2_mrd",   {31'd0, mem_read}, 32'd1);
        check_val("miss_c2_maddr", {16'd0, mem_addr}, 32'h0010);
        step();

        // Back-to-back load to the filled address hits.
        mem_rdata = 16'h0000;
        @(negedge clk);
        check_val("hit_ready", {31'd0, d_ready},  32'd1);
        check_val("hit_rdata", {16'd0, d_rdata},  32'hBEEF);
        check_val("hit_mrd",   {31'd0, mem_read}, 32'd0);
        step();
        check_val("hit_count1", {16'd0, hit_count}, 32'd1);

        // Store 0x1234 to 0x0010 keeps the buffer coherent.
        drive(1'b0, 1'b1, 16'h0010, 16'h1234);
        @(negedge clk);
        check_val("st_ready", {31'd0, d_ready},   32'd1);
        check_val("st_mwr",   {31'd0, mem_write}, 32'd1);
        check_val("st_maddr", {16'd0, mem_addr},  32'h0010);
        check_val("st_wdata", {16'd0, mem_wdata}, 32'h1234);
        check_val("st_rdata", {16'd0, d_rdata},   32'd0);
        check_val("st_mrd",   {31'd0, mem_read},  32'd0);
        step();
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        @(negedge clk);
        check_val("coh_ready", {31'd0, d_ready},  32'd1);
        check_val("coh_rdata", {16'd0, d_rdata},  32'h1234);
        check_val("coh_mrd",   {31'd0, mem_read}, 32'd0);
        step();
        check_val("hit_count2", {16'd0, hit_count}, 32'd2);

        // Store elsewhere leaves the buffer untouched.
        drive(1'b0, 1'b1, 16'h0020, 16'h5555);
        @(negedge clk);
        check_val("st2_maddr", {16'd0, mem_addr}, 32'h0020);
        step();
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        @(negedge clk);
        check_val("oth_ready", {31'd0, d_ready}, 32'd1);
        check_val("oth_rdata", {16'd0, d_rdata}, 32'h1234);
        step();
        mem_rdata = 16'hA5A5;
        drive(1'b1, 1'b0, 16'h0020, 16'h0000);
        @(negedge clk);
        check_val("m20_c0_ready", {31'd0, d_ready}, 32'd0);
        step();
        @(negedge clk);
        check_val("m20_c1_ready", {31'd0, d_ready}, 32'd0);
        step();
        @(negedge clk);
        check_val("m20_c2_ready", {31'd0, d_ready}, 32'd1);
        check_val("m20_c2_rdata", {16'd0, d_rdata}, 32'hA5A5);
        step();
        check_val("hit_count3", {16'd0, hit_count}, 32'd3);

        // Reset during cycle 1 of a miss abandons the read.
        mem_rdata = 16'h7777;
        drive(1'b1, 1'b0, 16'h0030, 16'h0000);
        step();
        @(negedge clk);
        check_val("rw_pre_mrd", {31'd0, mem_read}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("rw_mrd",   {31'd0, mem_read},  32'd0);
        check_val("rw_ready", {31'd0, d_ready},   32'd0);
        check_val("rw_hits",  {16'd0, hit_count}, 32'd0);
        step();
        reset_n = 1'b1;
        // 0x0020 was buffered before reset; it must miss now.
        mem_rdata = 16'h2222;
        drive(1'b1, 1'b0, 16'h0020, 16'h0000);
        @(negedge clk);
        check_val("rst_bufinv_ready", {31'd0, d_ready},  32'd0);
        check_val("rst_idle_mrd",     {31'd0, mem_read}, 32'd0);
        step();
        step();
        @(negedge clk);
        check_val("rst_refill_rdata", {16'd0, d_rdata}, 32'h2222);
        step();
        // Re-presented load to 0x0030 takes the full latency.
        mem_rdata = 16'h7777;
        drive(1'b1, 1'b0, 16'h0030, 16'h0000);
        @(negedge clk);
        check_val("rp_c0_ready", {31'd0, d_ready}, 32'd0);
        step();
        @(negedge clk);
        check_val("rp_c1_ready", {31'd0, d_ready},  32'd0);
        check_val("rp_c1_maddr", {16'd0, mem_addr}, 32'h0030);
        step();
        @(negedge clk);
        check_val("rp_c2_ready", {31'd0, d_ready}, 32'd1);
        check_val("rp_c2_rdata", {16'd0, d_rdata}, 32'h7777);
        step();

        // Illegal read+write is treated as a store.
        mem_rdata = 16'h0000;
        drive(1'b1, 1'b1, 16'h0030, 16'h3C3C);
        @(negedge clk);
        check_val("ill_mwr",   {31'd0, mem_write}, 32'd1);
        check_val("ill_mrd",   {31'd0, mem_read},  32'd0);
        check_val("ill_ready", {31'd0, d_ready},   32'd1);
        check_val("ill_rdata", {16'd0, d_rdata},   32'd0);
        step();
        check_val("ill_hits", {16'd0, hit_count}, 32'd0);
        drive(1'b1, 1'b0, 16'h0030, 16'h0000);
        @(negedge clk);
        check_val("ill_coh_rdata", {16'd0, d_rdata}, 32'h3C3C);

        // Drive hit_count to saturation, then hit once more.
        for (int i = 0; i < 65535; i++) begin
            step();
        end
        check_val("sat_ffff", {16'd0, hit_count}, 32'h0000FFFF);
        @(negedge clk);
        check_val("sat_ready", {31'd0, d_ready}, 32'd1);
        step();
        check_val("sat_hold", {16'd0, hit_count}, 32'h0000FFFF);

        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
